// File: rtl/seq_stage_ctrl_pkg.sv
// Shared constants for the SEQ stage sequencer: Y86-64 instruction codes,
// processor status codes and the sequencer state encodings.
package seq_stage_ctrl_pkg;

    // Y86-64 instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Processor status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    // Sequencer state encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEMORY    = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;
    localparam logic [2:0] ST_PCUPD     = 3'd6;
    localparam logic [2:0] ST_HALTED    = 3'd7;

    // Instructions that touch data memory and therefore visit MEMORY
    function automatic logic is_mem_icode(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == IMRMOVQ) || (ic == ICALL) ||
               (ic == IRET)    || (ic == IPUSHQ)  || (ic == IPOPQ);
    endfunction

endpackage

// File: rtl/seq_ctrl_perf.sv
// Performance counters for the SEQ stage sequencer: retired instructions and
// running cycles. Both wrap modulo 2^CNT_W.
module seq_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             running,
    input  logic             retire,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    // Count completed instructions and cycles spent running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
            cycles  <= '0;
        end else begin
            if (retire)
                retired <= retired + 1'b1;
            if (running)
                cycles <= cycles + 1'b1;
        end
    end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the SEQ Y86-64 core. Steps F/D/E/M/W/PC one
// at a time with registered one-hot enables, holds MEMORY until the data
// handshake completes (or times out) and owns the status code.
// Optional: define SEQ_CTRL_PERF_EN to build the retired/cycles counters.
module seq_stage_ctrl
    import seq_stage_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             dmem_ready,
    input  logic             dmem_error,
    output logic             f_en,
    output logic             d_en,
    output logic             e_en,
    output logic             m_en,
    output logic             w_en,
    output logic             pc_en,
    output logic             dmem_req,
    output logic [2:0]       stat,
    output logic             running,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    // Last wait count before the timeout fires: the MEM_TIMEOUT-th cycle
    // without dmem_ready sees MEM_TIMEOUT-1 in the counter.
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    logic [2:0]      state, state_nxt;
    logic [2:0]      stat_nxt;
    logic [WC_W-1:0] wait_cnt, wait_nxt;

    // Next-state, status and memory wait counter decisions
    always_comb begin
        state_nxt = state;
        stat_nxt  = stat;
        wait_nxt  = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_error) begin
                    stat_nxt  = SADR;
                    state_nxt = ST_HALTED;
                end else if (icode > IPOPQ) begin
                    stat_nxt  = SINS;
                    state_nxt = ST_HALTED;
                end else if (icode == IHALT) begin
                    stat_nxt  = SHLT;
                    state_nxt = ST_HALTED;
                end else begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: state_nxt = ST_EXECUTE;
            ST_EXECUTE: begin
                if (is_mem_icode(icode)) begin
                    state_nxt = ST_MEMORY;
                    wait_nxt  = '0;
                end else begin
                    state_nxt = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (dmem_error) begin
                    stat_nxt  = SADR;
                    state_nxt = ST_HALTED;
                end else if (dmem_ready) begin
                    state_nxt = ST_WRITEBACK;
                end else if (wait_cnt == WC_LAST) begin
                    stat_nxt  = SADR;
                    state_nxt = ST_HALTED;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            ST_WRITEBACK: state_nxt = ST_PCUPD;
            ST_PCUPD:     state_nxt = ST_FETCH;
            ST_HALTED:    state_nxt = ST_HALTED;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // State, status and wait counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            stat     <= SAOK;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            stat     <= stat_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Registered one-hot decode of the next state onto the stage enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_en     <= 1'b0;
            d_en     <= 1'b0;
            e_en     <= 1'b0;
            m_en     <= 1'b0;
            w_en     <= 1'b0;
            pc_en    <= 1'b0;
            dmem_req <= 1'b0;
            running  <= 1'b0;
        end else begin
            f_en     <= (state_nxt == ST_FETCH);
            d_en     <= (state_nxt == ST_DECODE);
            e_en     <= (state_nxt == ST_EXECUTE);
            m_en     <= (state_nxt == ST_MEMORY);
            w_en     <= (state_nxt == ST_WRITEBACK);
            pc_en    <= (state_nxt == ST_PCUPD);
            dmem_req <= (state_nxt == ST_MEMORY);
            running  <= (state_nxt != ST_IDLE) && (state_nxt != ST_HALTED);
        end
    end

`ifdef SEQ_CTRL_PERF_EN
    logic retire;
    assign retire = (state == ST_PCUPD);

    seq_ctrl_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk     (clk),
        .rst     (rst),
        .running (running),
        .retire  (retire),
        .retired (retired),
        .cycles  (cycles)
    );
`else
    assign retired = '0;
    assign cycles  = '0;
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Testbench for seq_stage_ctrl: directed cases followed by random instruction
// streams, checked cycle by cycle against an expected per-instruction stage
// trace built from the sequencing rules.
module tb_seq_stage_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    // Observed enable vector: {dmem_req, pc, w, m, e, d, f}
    localparam logic [6:0] V_F = 7'b0000001;
    localparam logic [6:0] V_D = 7'b0000010;
    localparam logic [6:0] V_E = 7'b0000100;
    localparam logic [6:0] V_M = 7'b1001000;
    localparam logic [6:0] V_W = 7'b0010000;
    localparam logic [6:0] V_P = 7'b0100000;

    // How a MEMORY stay resolves after k cycles with dmem_ready low
    localparam int MR_READY   = 0;
    localparam int MR_ERROR   = 1;
    localparam int MR_BOTH    = 2;
    localparam int MR_TIMEOUT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       icode = 4'h1;
    logic             imem_error = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             dmem_error = 1'b0;
    logic             f_en, d_en, e_en, m_en, w_en, pc_en, dmem_req;
    logic [2:0]       stat;
    logic             running;
    logic [CNT_W-1:0] retired, cycles;

    int unsigned      n_vec = 0;
    int unsigned      n_bad = 0;
    int unsigned      n_instr = 0;
    logic [2:0]       exp_stat = SAOK;
    logic [CNT_W-1:0] exp_retired = '0;
    logic [CNT_W-1:0] exp_cycles = '0;

    always #5 clk = ~clk;

    seq_stage_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .icode      (icode),
        .imem_error (imem_error),
        .dmem_ready (dmem_ready),
        .dmem_error (dmem_error),
        .f_en       (f_en),
        .d_en       (d_en),
        .e_en       (e_en),
        .m_en       (m_en),
        .w_en       (w_en),
        .pc_en      (pc_en),
        .dmem_req   (dmem_req),
        .stat       (stat),
        .running    (running),
        .retired    (retired),
        .cycles     (cycles)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] en_vec();
        return {dmem_req, pc_en, w_en, m_en, e_en, d_en, f_en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the expectation for the current cycle
    task automatic check_cycle(input string tag, input logic [6:0] exp_vec, input logic exp_run);
        check_eq({tag, ".en"}, en_vec(), exp_vec);
        check_eq({tag, ".running"}, running, exp_run);
        check_eq({tag, ".stat"}, stat, exp_stat);
`ifdef SEQ_CTRL_PERF_EN
        check_eq({tag, ".retired"}, retired, exp_retired);
        check_eq({tag, ".cycles"}, cycles, exp_cycles);
`else
        check_eq({tag, ".retired"}, retired, '0);
        check_eq({tag, ".cycles"}, cycles, '0);
`endif
        if (exp_run)
            exp_cycles = exp_cycles + 1'b1;
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        exp_stat    = SAOK;
        exp_retired = '0;
        exp_cycles  = '0;
        check_cycle("reset", '0, 1'b0);
        #2 rst = 1'b0;
    endtask

    // One idle cycle with start low, then request start for the next edge
    task automatic begin_run();
        start = 1'b0;
        tick();
        check_cycle("idle", '0, 1'b0);
        start = 1'b1;
    endtask

    // Run one instruction; outcome 0 = retired, 1 = halted, 2 = reset mid-way
    task automatic run_instr(input logic [3:0] ic, input logic ie, input int mtype,
                             input int k, input int rst_at, output int outcome);
        logic [6:0] tr[$];
        logic [2:0] hstat;
        logic       halts;
        int         nm;
        int         mi;
        string      tag;

        n_instr++;
        halts = 1'b0;
        hstat = SAOK;
        tr.push_back(V_F);
        if (ie) begin
            halts = 1'b1; hstat = SADR;
        end else if (ic > 4'hB) begin
            halts = 1'b1; hstat = SINS;
        end else if (ic == 4'h0) begin
            halts = 1'b1; hstat = SHLT;
        end else begin
            tr.push_back(V_D);
            tr.push_back(V_E);
            if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
                nm = (mtype == MR_TIMEOUT) ? MEM_TIMEOUT : k + 1;
                for (int j = 0; j < nm; j++)
                    tr.push_back(V_M);
                if (mtype != MR_READY) begin
                    halts = 1'b1; hstat = SADR;
                end
            end
            if (!halts) begin
                tr.push_back(V_W);
                tr.push_back(V_P);
            end
        end

        mi = 0;
        for (int i = 0; i < tr.size(); i++) begin
            tick();
            tag = $sformatf("i%0d.c%0d", n_instr, i);
            check_cycle(tag, tr[i], 1'b1);
            if (i == rst_at) begin
                async_reset();
                outcome = 2;
                return;
            end
            start = 1'($urandom_range(0, 1));
            if (tr[i] == V_F) begin
                icode      = ic;
                imem_error = ie;
            end
            if (tr[i] == V_M) begin
                if (mtype == MR_TIMEOUT || mi < k) begin
                    dmem_ready = 1'b0;
                    dmem_error = 1'b0;
                end else begin
                    dmem_ready = (mtype == MR_READY) || (mtype == MR_BOTH);
                    dmem_error = (mtype == MR_ERROR) || (mtype == MR_BOTH);
                end
                mi++;
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_error = 1'($urandom_range(0, 1));
            end
        end

        if (halts) begin
            exp_stat = hstat;
            for (int h = 0; h < 3; h++) begin
                tick();
                check_cycle($sformatf("i%0d.halted%0d", n_instr, h), '0, 1'b0);
                start      = 1'($urandom_range(0, 1));
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_error = 1'($urandom_range(0, 1));
            end
            outcome = 1;
        end else begin
            exp_retired = exp_retired + 1'b1;
            outcome = 0;
        end
    endtask

    // Run one instruction and restart the core if it did not retire
    task automatic step(input logic [3:0] ic, input logic ie, input int mtype,
                        input int k, input int rst_at);
        int oc;
        run_instr(ic, ie, mtype, k, rst_at, oc);
        if (oc == 1)
            async_reset();
        if (oc != 0)
            begin_run();
    endtask

    initial begin
        logic [3:0] ic;
        logic       ie;
        int         mt, kk, ra, r;

        tick();
        async_reset();
        begin_run();

        // Directed cases
        step(4'h6, 1'b0, MR_READY, 0, -1);                // OPq: F D E W P
        step(4'h5, 1'b0, MR_READY, 3, -1);                // MRMOVQ, 3 wait cycles
        step(4'h1, 1'b0, MR_READY, 0, -1);                // NOP back to back
        step(4'h5, 1'b0, MR_READY, MEM_TIMEOUT - 1, -1);  // ready on the timeout cycle
        step(4'hA, 1'b0, MR_TIMEOUT, 0, -1);              // PUSHQ never ready
        step(4'h0, 1'b0, MR_READY, 0, -1);                // HALT
        step(4'hC, 1'b0, MR_READY, 0, -1);                // invalid icode
        step(4'hC, 1'b1, MR_READY, 0, -1);                // fetch fault beats invalid
        step(4'h4, 1'b0, MR_BOTH, 0, -1);                 // error beats ready
        step(4'h8, 1'b0, MR_ERROR, 5, -1);                // late memory error
        step(4'h6, 1'b0, MR_READY, 0, 2);                 // reset during EXECUTE
        step(4'h9, 1'b0, MR_READY, 1, -1);                // fresh start after reset

        // Random instruction stream
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0)
                ic = 4'($urandom_range(0, 15));
            else
                ic = 4'($urandom_range(1, 11));
            ie = ($urandom_range(0, 31) == 0);
            r  = int'($urandom_range(0, 19));
            mt = (r == 0) ? MR_ERROR : (r == 1) ? MR_BOTH : (r == 2) ? MR_TIMEOUT : MR_READY;
            if ($urandom_range(0, 3) == 0)
                kk = int'($urandom_range(0, MEM_TIMEOUT - 1));
            else
                kk = int'($urandom_range(0, 3));
            ra = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 3)) : -1;
            step(ic, ie, mt, kk, ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
# seq_stage_ctrl

Multi-cycle stage sequencer for the SEQ Y86-64 core. It steps the Fetch, Decode, Execute, Memory, Write-back and PC-update stages one at a time with registered one-hot enables. It holds the Memory stage until the data-memory handshake completes and owns the processor status code (AOK/HLT/ADR/INS). It sits between the top-level core wrapper and the per-stage datapath blocks.

## Interface
Parameters:
- MEM_TIMEOUT, default 16: maximum number of cycles spent in MEMORY waiting for dmem_ready before an ADR fault.
- CNT_W, default 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  level; begins execution when sampled high in IDLE.
- icode  in  4  instruction code from Fetch; valid while f_en is high and stable afterwards.
- imem_error  in  1  instruction fetch fault; sampled with icode.
- dmem_ready  in  1  data memory completed the access; sampled in MEMORY.
- dmem_error  in  1  data memory fault; sampled in MEMORY.
- f_en, d_en, e_en, m_en, w_en, pc_en  out  1 each  stage enables; at most one is high in any cycle.
- dmem_req  out  1  data access request; high for the whole MEMORY stay.
- stat  out  3  status: SAOK=1, SHLT=2, SADR=3, SINS=4.
- running  out  1  high in every state except IDLE and HALTED.
- retired  out  CNT_W  count of instructions that completed PCUPD.
- cycles  out  CNT_W  count of cycles with running high.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED.
- Stage enables and dmem_req are a registered one-hot decode of the next state (Moore outputs). FETCH→f_en, DECODE→d_en, EXECUTE→e_en, MEMORY→m_en and dmem_req, WRITEBACK→w_en, PCUPD→pc_en.
- IDLE → FETCH when start=1. start is ignored in every other state.
- In FETCH, the following checks are made in priority order:
  - imem_error=1 → stat=SADR, go to HALTED.
  - icode > 4'hB → stat=SINS, go to HALTED.
  - icode=IHALT → stat=SHLT, go to HALTED.
  - Otherwise go to DECODE.
- DECODE → EXECUTE.
- EXECUTE → MEMORY if icode ∈ {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ}; otherwise → WRITEBACK.
- MEMORY exits as follows:
  - dmem_error=1 → stat=SADR, go to HALTED. If dmem_error and dmem_ready are high in the same cycle, the error wins.
  - Else dmem_ready=1 → WRITEBACK.
  - Else the wait counter increments. When the counter reaches MEM_TIMEOUT, stat=SADR and go to HALTED. If dmem_ready is high in the same cycle the timeout would fire, ready wins.
- WRITEBACK → PCUPD.
- PCUPD → FETCH, and retired increments.
- HALTED is absorbing: all enables are 0, stat holds its value, and only rst leaves this state.
- The wait counter clears on every entry to MEMORY. Its width is clog2(MEM_TIMEOUT+1).

## Timing
- Reset values: state=IDLE; all enables, dmem_req and running are 0; stat=SAOK; retired=0; cycles=0.
- rst asserted mid-instruction forces IDLE immediately and asynchronously. Partially sequenced stages are abandoned, and no pc_en is issued.
- With start high at edge N, f_en is high during cycle N+1.
- Non-memory instruction: 5 cycles (F, D, E, W, PC).
- Memory instruction: 6+k cycles, where k is the number of cycles in which dmem_ready was low.
- Back-to-back instructions: f_en rises in the cycle immediately after pc_en.
- A fault reported in FETCH: no d_en follows, and stat updates at the same edge that enters HALTED.
- retired and cycles wrap modulo 2^CNT_W.

## Configuration
- Macro SEQ_CTRL_PERF_EN.
- Defined: the retired and cycles counters are implemented as described above.
- Undefined: the counter logic is not built, retired and cycles are tied to 0, and the port list is unchanged.

## Structure
- defines.v holds the existing icode constants (IHALT…IPOPQ) and receives new entries for the stat codes SAOK, SHLT, SADR, SINS and the state encodings.
- Optional sub-module seq_ctrl_perf holds both counters and is instantiated only under SEQ_CTRL_PERF_EN.
- The FSM and the memory wait counter stay in seq_stage_ctrl.

## Test plan
- Reset then start=1, icode=IOPQ (6): f, d, e, w, pc enables are each high for one cycle, in order, on consecutive cycles; m_en is never high; retired=1 after pc_en.
- icode=IMRMOVQ (5) with dmem_ready held low for 3 MEMORY cycles, then high: m_en and dmem_req are high for 4 cycles, then w_en; total 9 cycles.
- icode=IPUSHQ (A) with dmem_ready never high and MEM_TIMEOUT=16: after 16 MEMORY cycles stat=3, HALTED, and all enables stay 0.
- In FETCH: icode=IHALT (0) gives stat=2; icode=4'hC gives stat=4; imem_error=1 together with icode=4'hC gives stat=3 (ADR takes priority). No d_en in any of these cases.
- dmem_ready and dmem_error both high in the first MEMORY cycle → stat=3 and HALTED, with no w_en.
- rst pulsed during EXECUTE → outputs return to their reset values asynchronously, and a following start begins a fresh FETCH.
